// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin, packet-locked arbiter sharing one FIFO write port among
//   NREQ requesters. A grant is held until the owner's end-of-packet word
//   (bit DW-1) is written, or until MAXLEN words have been written, in which
//   case the packet is forcibly released and err_overlen pulses.
// Ports:
//   clk0, rst        write-domain clock, async active-high reset
//   req_valid/data   per-requester word offer (data packed at [i*DW +: DW])
//   req_ready        per-requester accept (combinational)
//   readyin          FIFO backpressure
//   we, datain       FIFO write port (combinational)
//   grant            registered one-hot grant, zero when idle
//   err_overlen      one-cycle pulse on forced release
//   pkt_done         one-cycle pulse on normal end of packet

// Per-requester slice: gates ready/transfer/data by this lane's grant bit.
module fifo_wr_arbiter_lane #(
  parameter int DW = 9
) (
  input  logic          gnt,
  input  logic          valid,
  input  logic          readyin,
  input  logic [DW-1:0] data,
  output logic          ready,
  output logic          xfer,
  output logic [DW-1:0] data_out
);
  assign ready    = gnt & readyin;
  assign xfer     = gnt & valid & readyin;
  assign data_out = gnt ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter int NREQ   = 4,
  parameter int DW     = 9,
  parameter int MAXLEN = 64
) (
  input  logic               clk0,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               readyin,
  output logic               we,
  output logic [DW-1:0]      datain,
  output logic [NREQ-1:0]    grant,
  output logic               err_overlen,
  output logic               pkt_done
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAXLEN) + 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                     state, state_n;
  logic [NREQ-1:0]            grant_n;
  logic [PW-1:0]              gidx, gidx_n, rr_ptr, rr_n, pick;
  logic [CW-1:0]              wcnt, wcnt_n, wcnt_inc;
  logic                       done_n, ovl_n, found, last;
  logic [NREQ-1:0]            lane_xfer;
  logic [NREQ-1:0][DW-1:0]    lane_data;

  // Grant is all-zero outside LOCK, so the lanes alone keep the port quiet
  // while idle.
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    fifo_wr_arbiter_lane #(.DW(DW)) u_lane (
      .gnt      (grant[i]),
      .valid    (req_valid[i]),
      .readyin  (readyin),
      .data     (req_data[i*DW +: DW]),
      .ready    (req_ready[i]),
      .xfer     (lane_xfer[i]),
      .data_out (lane_data[i])
    );
  end

  always_comb begin
    datain = '0;
    for (int i = 0; i < NREQ; i++) datain = datain | lane_data[i];
  end

  assign we       = |lane_xfer;
  assign last     = datain[DW-1];
  assign wcnt_inc = wcnt + CW'(1);

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        pick  = PW'((int'(rr_ptr) + k) % NREQ);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    gidx_n  = gidx;
    rr_n    = rr_ptr;
    wcnt_n  = wcnt;
    done_n  = 1'b0;
    ovl_n   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_n = NREQ'(1) << pick;
          gidx_n  = pick;
          wcnt_n  = '0;
          state_n = LOCK;
        end
      end
      LOCK: begin
        if (we) begin
          wcnt_n = wcnt_inc;
          // Last flag wins over the length limit when both hit together.
          if (last || wcnt_inc == CW'(MAXLEN)) begin
            done_n  = last;
            ovl_n   = !last;
            state_n = IDLE;
            grant_n = '0;
            rr_n    = (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      gidx        <= '0;
      rr_ptr      <= '0;
      wcnt        <= '0;
      pkt_done    <= 1'b0;
      err_overlen <= 1'b0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      gidx        <= gidx_n;
      rr_ptr      <= rr_n;
      wcnt        <= wcnt_n;
      pkt_done    <= done_n;
      err_overlen <= ovl_n;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ns
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, DW = 9, MAXLEN = 4;

  logic               clk0 = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid, req_ready, grant;
  logic [NREQ*DW-1:0] req_data;
  logic               readyin, we, err_overlen, pkt_done;
  logic [DW-1:0]      datain;

  always #10 clk0 = ~clk0;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAXLEN(MAXLEN)) dut (
    .clk0(clk0), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .readyin(readyin), .we(we), .datain(datain),
    .grant(grant), .err_overlen(err_overlen), .pkt_done(pkt_done)
  );

  // requester word lists
  logic [DW-1:0] pw [NREQ][16];
  int            plen [NREQ];
  int            phead [NREQ];
  logic          hold [NREQ];
  logic [NREQ-1:0] acc;

  // scoreboard
  logic [NREQ+DW-1:0] wq[$];
  logic [NREQ-1:0]    gq[$];
  logic [1:0]         eq[$];
  int n_chk = 0, n_pass = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  task automatic fail_none(string nm, logic [31:0] act);
    n_chk++;
    $display("FAIL %s: got %0h, required nothing pending", nm, act);
  endtask

  always @(posedge clk0 or posedge rst)
    if (rst) acc <= '0;
    else     acc <= req_valid & req_ready;

  // driver: retire accepted words at negedge, present next words 2ns later
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk0);
      for (int i = 0; i < NREQ; i++)
        if (acc[i] && phead[i] < plen[i]) phead[i]++;
      #2;
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = (phead[i] < plen[i]) && !hold[i];
        req_data[i*DW +: DW] = req_valid[i] ? pw[i][phead[i]] : '0;
      end
    end
  end

  // monitor: samples just before each posedge
  initial begin
    logic [NREQ-1:0]    pg;
    logic [NREQ+DW-1:0] w;
    logic [NREQ-1:0]    g;
    logic [1:0]         e;
    pg = '0;
    forever begin
      @(negedge clk0);
      #4;
      if (!rst) begin
        if (we) begin
          if (wq.size() == 0) fail_none("unexpected_write", 32'(datain));
          else begin
            w = wq.pop_front();
            chk("write_data", 32'(datain), 32'(w[DW-1:0]));
            chk("write_grant", 32'(grant), 32'(w[NREQ+DW-1:DW]));
          end
        end
        if (grant != '0 && grant != pg) begin
          if (gq.size() == 0) fail_none("unexpected_grant", 32'(grant));
          else begin
            g = gq.pop_front();
            chk("grant_order", 32'(grant), 32'(g));
          end
        end
        if (pkt_done || err_overlen) begin
          if (eq.size() == 0) fail_none("unexpected_pulse", 32'({err_overlen, pkt_done}));
          else begin
            e = eq.pop_front();
            chk("release_pulse", 32'({err_overlen, pkt_done}), 32'(e));
          end
        end
        if (grant != '0) chk("req_ready", 32'(req_ready), 32'(grant & {NREQ{readyin}}));
        else             chk("idle_outputs", 32'({we, req_ready, datain}), 32'(0));
      end
      pg = grant;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk0);
    #1;
  endtask

  task automatic load(int r, logic [DW-1:0] d);
    pw[r][plen[r]] = d;
    plen[r]++;
  endtask

  task automatic exp_w(logic [NREQ-1:0] g, logic [DW-1:0] d);
    wq.push_back({g, d});
  endtask

  function automatic bit all_done();
    bit ok = (wq.size() == 0) && (gq.size() == 0) && (eq.size() == 0);
    for (int i = 0; i < NREQ; i++) if (phead[i] < plen[i]) ok = 1'b0;
    return ok;
  endfunction

  task automatic wait_grant(logic [NREQ-1:0] g, string nm);
    int n = 0;
    while (grant !== g && n < 60) begin tick(); n++; end
    chk(nm, 32'(grant), 32'(g));
  endtask

  task automatic drain(string nm);
    int n = 0;
    while (!all_done() && n < 300) begin tick(); n++; end
    tick();
    tick();
    chk(nm, 32'(all_done()), 32'(1));
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) begin plen[i] = 0; phead[i] = 0; hold[i] = 1'b0; end
  endtask

  initial begin
    int n;
    clear_reqs();
    readyin = 1'b1;
    rst     = 1'b1;
    #5;
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_outputs", 32'({we, req_ready, datain, pkt_done, err_overlen}), 32'(0));
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_grant", 32'(grant), 32'(0));
    chk("post_rst_outputs", 32'({we, req_ready, datain, pkt_done, err_overlen}), 32'(0));

    // round robin over 1-word packets from rr_ptr = 0: 0,1,2,3,0
    gq.push_back(4'b0001); gq.push_back(4'b0010); gq.push_back(4'b0100);
    gq.push_back(4'b1000); gq.push_back(4'b0001);
    exp_w(4'b0001, 9'h1A0); exp_w(4'b0010, 9'h1A1); exp_w(4'b0100, 9'h1A2);
    exp_w(4'b1000, 9'h1A3); exp_w(4'b0001, 9'h1B0);
    for (int i = 0; i < 5; i++) eq.push_back(2'b01);
    load(0, 9'h1A0); load(0, 9'h1B0);
    load(1, 9'h1A1); load(2, 9'h1A2); load(3, 9'h1A3);
    drain("rr_drain");

    // 3-word packet from requester 0
    clear_reqs();
    gq.push_back(4'b0001);
    exp_w(4'b0001, 9'h011); exp_w(4'b0001, 9'h022); exp_w(4'b0001, 9'h133);
    eq.push_back(2'b01);
    load(0, 9'h011); load(0, 9'h022); load(0, 9'h133);
    drain("single_drain");

    // readyin 1,0,0,1 during a 4-word packet from requester 2
    clear_reqs();
    gq.push_back(4'b0100);
    exp_w(4'b0100, 9'h041); exp_w(4'b0100, 9'h042);
    exp_w(4'b0100, 9'h043); exp_w(4'b0100, 9'h144);
    eq.push_back(2'b01);
    load(2, 9'h041); load(2, 9'h042); load(2, 9'h043); load(2, 9'h144);
    wait_grant(4'b0100, "bp_grant");
    for (int i = 0; i < 2; i++) begin
      tick();
      readyin = 1'b0;
      #3;
      chk("bp_hold_grant", 32'(grant), 32'(4'b0100));
      chk("bp_no_write", 32'({we, req_ready}), 32'(0));
    end
    tick();
    readyin = 1'b1;
    drain("bp_drain");

    // over-length: 4 words without last flag from requester 1
    clear_reqs();
    gq.push_back(4'b0010); gq.push_back(4'b0100);
    gq.push_back(4'b1000); gq.push_back(4'b0010);
    exp_w(4'b0010, 9'h001); exp_w(4'b0010, 9'h002);
    exp_w(4'b0010, 9'h003); exp_w(4'b0010, 9'h004);
    exp_w(4'b0100, 9'h1C2); exp_w(4'b1000, 9'h1C3); exp_w(4'b0010, 9'h105);
    eq.push_back(2'b10); eq.push_back(2'b01); eq.push_back(2'b01); eq.push_back(2'b01);
    load(1, 9'h001); load(1, 9'h002); load(1, 9'h003); load(1, 9'h004);
    wait_grant(4'b0010, "ovl_grant");
    load(1, 9'h105); load(2, 9'h1C2); load(3, 9'h1C3);
    drain("ovl_drain");

    // reset after 2nd word of a 5-word packet
    clear_reqs();
    gq.push_back(4'b0001);
    exp_w(4'b0001, 9'h051); exp_w(4'b0001, 9'h052);
    load(0, 9'h051); load(0, 9'h052); load(0, 9'h053); load(0, 9'h054); load(0, 9'h155);
    n = 0;
    while (phead[0] < 2 && n < 60) begin tick(); n++; end
    chk("rst_mid_reach", 32'(phead[0]), 32'(2));
    clear_reqs();
    rst = 1'b1;
    #1;
    chk("rst_mid_grant", 32'(grant), 32'(0));
    chk("rst_mid_we", 32'({we, req_ready, pkt_done, err_overlen}), 32'(0));
    tick(); tick();
    rst = 1'b0;
    gq.push_back(4'b0001); gq.push_back(4'b1000);
    exp_w(4'b0001, 9'h1D0); exp_w(4'b1000, 9'h1D3);
    eq.push_back(2'b01); eq.push_back(2'b01);
    load(0, 9'h1D0); load(3, 9'h1D3);
    drain("rst_drain");

    // requester 3 drops valid for 5 cycles; last word also hits MAXLEN
    clear_reqs();
    gq.push_back(4'b1000); gq.push_back(4'b0001);
    exp_w(4'b1000, 9'h061); exp_w(4'b1000, 9'h062);
    exp_w(4'b1000, 9'h063); exp_w(4'b1000, 9'h164); exp_w(4'b0001, 9'h1E0);
    eq.push_back(2'b01); eq.push_back(2'b01);
    load(3, 9'h061); load(3, 9'h062); load(3, 9'h063); load(3, 9'h164);
    wait_grant(4'b1000, "gap_grant");
    load(0, 9'h1E0);
    n = 0;
    while (phead[3] < 2 && n < 60) begin tick(); n++; end
    chk("gap_reach", 32'(phead[3]), 32'(2));
    hold[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("gap_hold_grant", 32'(grant), 32'(4'b1000));
      chk("gap_no_write", 32'(we), 32'(0));
      tick();
    end
    hold[3] = 1'b0;
    drain("gap_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
